mem_byte_lsu: RTL and testbench

Load/store initiator between the EX/MEM pipeline register and a byte-wide data memory port. It turns one 16-bit load or store from the pipeline into two sequential byte transactions, big-endian: the high byte goes to `addr` and the low byte to `addr+1`. It stalls the pipeline until both beats are acknowledged, then presents the assembled load word.

---
 rtl/mem_byte_lsu_if.sv | 21 ++
 rtl/mem_byte_lsu.sv | 151 +++++++++++++++
 tb/tb_mem_byte_lsu.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_byte_lsu_if.sv
// Byte-wide data memory port between the LSU (master) and memory (slave).
interface mem_byte_lsu_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wbyte;
  logic              mem_ack;
  logic [7:0]        mem_rbyte;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wbyte,
    input  mem_ack, mem_rbyte
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wbyte,
    output mem_ack, mem_rbyte
  );
endinterface

// File: rtl/mem_byte_lsu.sv
// 16-bit load/store split into two big-endian byte beats.
// Optional odd-address trap: define LSU_ALIGN_CHECK_EN.
module mem_byte_lsu #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              stall,
  output logic [15:0]       rdata,
  output logic              rdata_valid,
  output logic              misaligned,
  mem_byte_lsu_if.master    mem
);

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ld_q, ld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        shadow_q, shadow_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        wbyte_q, wbyte_d;
`ifdef LSU_ALIGN_CHECK_EN
  logic              mis_q, mis_d;
`endif

  logic go;
  assign go = MemRead | MemWrite;

  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    addr_d   = addr_q;
    lo_d     = lo_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    wbyte_d  = wbyte_q;
`ifdef LSU_ALIGN_CHECK_EN
    mis_d    = 1'b0;
`endif
    stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          stall  = 1'b1;
          ld_d   = MemRead & ~MemWrite;
          addr_d = req_addr;
          lo_d   = req_wdata[7:0];
`ifdef LSU_ALIGN_CHECK_EN
          if (req_addr[0]) begin
            state_d = DONE;
            ld_d    = 1'b0;
            mis_d   = 1'b1;
          end else
`endif
          begin
            state_d = HI;
            req_d   = 1'b1;
            we_d    = MemWrite;
            maddr_d = req_addr;
            wbyte_d = req_wdata[15:8];
          end
        end
      end
      HI: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          if (ld_q) shadow_d = mem.mem_rbyte;
          maddr_d = addr_q + 1'b1;
          wbyte_d = lo_q;
          state_d = LO;
        end
      end
      LO: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          if (ld_q) rdata_d = {shadow_q, mem.mem_rbyte};
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ld_q     <= 1'b0;
      addr_q   <= '0;
      lo_q     <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      wbyte_q  <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      addr_q   <= addr_d;
      lo_q     <= lo_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      wbyte_q  <= wbyte_d;
`ifdef LSU_ALIGN_CHECK_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign rdata         = rdata_q;
  assign rdata_valid   = (state_q == DONE) & ld_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wbyte = wbyte_q;
`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned    = mis_q;
`else
  assign misaligned    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_byte_lsu.sv
// Bench for mem_byte_lsu: transaction-level memory model, random ops,
// per-cycle bus/rdata checks and a few hand-computed cases.
module tb_mem_byte_lsu;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemRead, MemWrite;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic          stall;
  logic [15:0]   rdata;
  logic          rdata_valid;
  logic          misaligned;

  mem_byte_lsu_if #(.ADDR_W(AW)) bus ();

  mem_byte_lsu #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misaligned  (misaligned),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // memory as the DUT sees it, and the reference at transaction level
  logic [7:0] mem  [0:65535];
  logic [7:0] refm [0:65535];

  int wait_mode = 0;  // 0 zero-wait, 1 fixed waits, 2 random waits
  int fixed_n   = 0;

  // current op as seen by the model
  logic        cur_ld  = 1'b0;
  logic        cur_we  = 1'b0;
  logic [15:0] cur_addr = '0;
  logic [15:0] cur_wd   = '0;
  logic [15:0] cur_exp  = '0;

  // cumulative observations from the compare process
  int beat_cycles = 0;
  int ack_seen    = 0;
  int rv_seen     = 0;
  int mis_seen    = 0;

  // memory responder
  initial begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
    bus.mem_ack   = 1'b0;
    bus.mem_rbyte = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        case (wait_mode)
          0: bus.mem_ack = 1'b1;
          1: begin
            if (cnt >= fixed_n) begin
              bus.mem_ack = 1'b1;
              cnt = 0;
            end else begin
              bus.mem_ack = 1'b0;
              cnt++;
            end
          end
          default: bus.mem_ack = ($urandom_range(0, 2) != 0);
        endcase
      end else begin
        cnt = 0;
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
      if (bus.mem_req && bus.mem_ack && !bus.mem_we)
        bus.mem_rbyte = mem[bus.mem_addr];
      else
        bus.mem_rbyte = 8'($urandom);
      @(negedge clk);
      if (!reset && bus.mem_req && bus.mem_ack && bus.mem_we)
        mem[bus.mem_addr] = bus.mem_wbyte;
    end
  end

  // compare process
  initial begin
    int          beat_idx;
    logic        prev_hold;
    logic [33:0] prev_bus;
    logic [15:0] prev_rdata;
    logic [15:0] ea;
    beat_idx   = 0;
    prev_hold  = 1'b0;
    prev_bus   = '0;
    prev_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        beat_idx   = 0;
        prev_hold  = 1'b0;
        prev_rdata = rdata;
      end else begin
`ifndef LSU_ALIGN_CHECK_EN
        chk("misaligned_off", misaligned, 0);
`else
        if (misaligned) mis_seen++;
`endif
        if (prev_hold)
          chk("req_stable", {bus.mem_req, bus.mem_we, bus.mem_addr,
                             bus.mem_wbyte}, prev_bus);
        if (bus.mem_req) begin
          beat_cycles++;
          chk("stall_in_beat", stall, 1);
          if (bus.mem_ack) begin
            ea = (beat_idx == 1) ? cur_addr + 16'd1 : cur_addr;
            chk("beat_addr", bus.mem_addr, ea);
            chk("beat_we", bus.mem_we, cur_we);
            if (cur_we)
              chk("beat_wbyte", bus.mem_wbyte,
                  (beat_idx == 1) ? cur_wd[7:0] : cur_wd[15:8]);
            beat_idx = 1 - beat_idx;
            ack_seen++;
          end
        end
        prev_hold = bus.mem_req && !bus.mem_ack;
        prev_bus  = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wbyte};
        if (rdata_valid) begin
          rv_seen++;
          chk("rdata", rdata, cur_exp);
        end else begin
          chk("rdata_hold", rdata, prev_rdata);
        end
        prev_rdata = rdata;
      end
    end
  end

  int b0, a0, r0, m0;
  logic cur_odd = 1'b0;

  task automatic snap();
    b0 = beat_cycles;
    a0 = ack_seen;
    r0 = rv_seen;
    m0 = mis_seen;
  endtask

  // called at posedge+2: present request and update the reference
  task automatic issue(input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd);
    logic [15:0] a1;
    a1 = a + 16'd1;
`ifdef LSU_ALIGN_CHECK_EN
    cur_odd = a[0];
`else
    cur_odd = 1'b0;
`endif
    cur_ld   = rd && !wr && !cur_odd;
    cur_we   = wr;
    cur_addr = a;
    cur_wd   = wd;
    cur_exp  = {refm[a], refm[a1]};
    if (wr && !cur_odd) begin
      refm[a]  = wd[15:8];
      refm[a1] = wd[7:0];
    end
    snap();
    MemRead   = rd;
    MemWrite  = wr;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic finish_op(output int nstall);
    bit done;
    done = 1'b0;
    nstall = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      #1;
      if (!stall) done = 1'b1;
      else nstall++;
    end
    if (!done) chk("stall_timeout", 1, 0);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    chk("stall_cycles", nstall, 1 + (beat_cycles - b0));
    chk("beat_count", ack_seen - a0, cur_odd ? 0 : 2);
    chk("rdata_valid_count", rv_seen - r0, {31'd0, cur_ld});
`ifdef LSU_ALIGN_CHECK_EN
    chk("misaligned_count", mis_seen - m0, {31'd0, cur_odd});
`endif
  endtask

  task automatic do_op(input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd,
                       input int gap, output int nstall);
    issue(rd, wr, a, wd);
    finish_op(nstall);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [15:0] a;
    logic [15:0] lst [0:10];
    for (int i = 0; i < 65536; i++) refm[i] = init_byte(i);
    reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_stall", stall, 0);
      chk("idle_req", bus.mem_req, 0);
      chk("idle_rdata", rdata, 16'h0000);
    end
    @(posedge clk);
    #2;

    // store 0xBEEF at 0x0010, zero-wait
    wait_mode = 0;
    do_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1, n);
    chk("store_stall", n, 3);
    chk("store_hi_byte", mem[16'h0010], 8'hBE);
    chk("store_lo_byte", mem[16'h0011], 8'hEF);

    // reset during the LO wait of a load; request stays held
    wait_mode = 1;
    fixed_n   = 6;
    issue(1'b1, 1'b0, 16'h0040, 16'h0000);
    k = 0;
    while (!(bus.mem_req && bus.mem_addr == 16'h0041) && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reach_lo_wait", k < 50, 1);
    reset = 1'b1;
    #1;
    chk("rst_req_async", bus.mem_req, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_stall_held", stall, 1);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    snap();
    finish_op(n);
    chk("restart_stall", n, 1 + 7 + 7);
    chk("restart_rdata", rdata, {init_byte(16'h40), init_byte(16'h41)});
    @(posedge clk);
    #2;

    // load 0x0010 with two waits per beat
    wait_mode = 1;
    fixed_n   = 2;
    do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 0, n);
    chk("load_wait_stall", n, 7);
    chk("load_wait_rdata", rdata, 16'hBEEF);

    wait_mode = 0;
`ifndef LSU_ALIGN_CHECK_EN
    do_op(1'b0, 1'b1, 16'hFFFF, 16'h1234, 0, n);
    chk("wrap_hi", mem[16'hFFFF], 8'h12);
    chk("wrap_lo", mem[16'h0000], 8'h34);
    do_op(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, n);
    chk("wrap_rdata", rdata, 16'h1234);
    do_op(1'b0, 1'b1, 16'h0021, 16'hA55A, 0, n);
    chk("odd_store_stall", n, 3);
    chk("odd_store_hi", mem[16'h0021], 8'hA5);
    chk("odd_store_lo", mem[16'h0022], 8'h5A);
`else
    do_op(1'b0, 1'b1, 16'h0021, 16'hA55A, 0, n);
    chk("mis_stall", n, 1);
    chk("mis_untouched", mem[16'h0021], init_byte(16'h21));
`endif

    // both requests high is a store
    do_op(1'b1, 1'b1, 16'h0030, 16'hC3D4, 0, n);
    chk("both_hi", mem[16'h0030], 8'hC3);
    chk("both_lo", mem[16'h0031], 8'hD4);

    // random traffic with random waits
    wait_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0)
        a = 16'hFFFE + 16'($urandom_range(0, 1));
      else
        a = 16'h0100 + 16'($urandom_range(0, 7));
      k = $urandom_range(0, 3);
      do_op(k == 0 || k == 2 || k == 3, k == 1 || k == 2, a,
            16'($urandom), $urandom_range(0, 2), n);
    end

    lst[0] = 16'hFFFE;
    lst[1] = 16'hFFFF;
    lst[2] = 16'h0000;
    for (int i = 0; i < 8; i++) lst[3 + i] = 16'h0100 + 16'(i);
    for (int i = 0; i < 11; i++)
      chk("mem_final", mem[lst[i]], refm[lst[i]]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
